// File: rtl/x7seg_capture.sv
// Receive side of a multiplexed 7-segment scan bus: deglitches a_to_g/an,
// decodes lit slots, infers blanked slots from dwell time and emits whole frames.
module x7seg_capture #(
  parameter int SLOT_CYCLES   = 262144,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 20
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [6:0]  a_to_g,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        valid,
  output logic        frame_stb,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] STAB_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STAB_ACC = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_HALF = CNT_W'(SLOT_CYCLES / 2);
  localparam logic [CNT_W-1:0] RUN_WRAP = CNT_W'(SLOT_CYCLES + SLOT_CYCLES / 2 - 1);

  // {ok, nibble}; ok=0 for any pattern outside the hex font
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b0000001: return 5'h10;
      7'b1001111: return 5'h11;
      7'b0010010: return 5'h12;
      7'b0000110: return 5'h13;
      7'b1001100: return 5'h14;
      7'b0100100: return 5'h15;
      7'b0100000: return 5'h16;
      7'b0001111: return 5'h17;
      7'b0000000: return 5'h18;
      7'b0000100: return 5'h19;
      7'b0001000: return 5'h1A;
      7'b1100000: return 5'h1B;
      7'b0110001: return 5'h1C;
      7'b1000010: return 5'h1D;
      7'b0110000: return 5'h1E;
      7'b0111000: return 5'h1F;
      default:    return 5'h00;
    endcase
  endfunction

  logic [6:0]       seg_q, seg_d, seg_prev_q, seg_prev_d;
  logic [3:0]       an_q, an_d, an_prev_q, an_prev_d;
  logic [CNT_W-1:0] stab_q, stab_d, run_q, run_d;
  logic             run_on_q, run_on_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       seen_q, seen_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       shadow_blank_q, shadow_blank_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       blank_q, blank_d;
  logic             valid_q, valid_d, frame_stb_q, frame_stb_d, err_q, err_d;

  logic             bus_changed, accept, rec, rec_blank;
  logic [1:0]       rec_slot, exp_slot, an_slot;
  logic [3:0]       rec_nib, slot_bit, seen_new;
  logic [4:0]       dec;

  always_comb begin
    seg_d          = a_to_g;
    seg_prev_d     = seg_q;
    an_d           = an;
    an_prev_d      = an_q;
    stab_d         = stab_q;
    run_on_d       = run_on_q;
    run_d          = run_q;
    ptr_d          = ptr_q;
    seen_d         = seen_q;
    shadow_d       = shadow_q;
    shadow_blank_d = shadow_blank_q;
    digits_d       = digits_q;
    blank_d        = blank_q;
    valid_d        = valid_q;
    frame_stb_d    = 1'b0;
    err_d          = 1'b0;
    rec            = 1'b0;
    rec_slot       = 2'd0;
    rec_nib        = 4'd0;
    rec_blank      = 1'b0;
    exp_slot       = ptr_q + 2'd1;
    slot_bit       = 4'd0;
    seen_new       = seen_q;
    dec            = seg_decode(seg_q);

    case (an_q)
      4'b1101: an_slot = 2'd1;
      4'b1011: an_slot = 2'd2;
      4'b0111: an_slot = 2'd3;
      default: an_slot = 2'd0;
    endcase

    bus_changed = (seg_q != seg_prev_q) || (an_q != an_prev_q);
    if (bus_changed) begin
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + CNT_ONE;
    end
    // saturation keeps a long stable run from ever matching the accept count again
    accept = (stab_d == STAB_ACC);

    if (bus_changed) begin
      run_on_d = 1'b0;
      run_d    = '0;
    end else if (run_on_q) begin
      run_d = (run_q == RUN_WRAP) ? RUN_HALF : run_q + CNT_ONE;
      if (run_q == RUN_HALF) begin
        rec       = 1'b1;
        rec_slot  = exp_slot;
        rec_blank = 1'b1;
      end
    end

    if (accept) begin
      case (an_q)
        4'b1110, 4'b1101, 4'b1011, 4'b0111: begin
          rec      = 1'b1;
          rec_slot = an_slot;
          rec_nib  = dec[3:0];
          if (!dec[4]) err_d = 1'b1;
        end
        4'b1111: begin
          run_on_d = 1'b1;
          run_d    = '0;
        end
        default: begin
          err_d  = 1'b1;
          seen_d = 4'd0;
        end
      endcase
    end

    if (rec) begin
      slot_bit = 4'b0001 << rec_slot;
      if (seen_q != 4'd0 && rec_slot != exp_slot) begin
        err_d    = 1'b1;
        seen_new = slot_bit;
      end else begin
        seen_new = seen_q | slot_bit;
      end
      shadow_d[{rec_slot, 2'b00} +: 4] = rec_nib;
      shadow_blank_d[rec_slot]         = rec_blank;
      ptr_d  = rec_slot;
      seen_d = seen_new;
      if (rec_slot == 2'd3) begin
        seen_d = 4'd0;
        if (seen_new == 4'hF) begin
          digits_d    = shadow_d;
          blank_d     = shadow_blank_d;
          valid_d     = 1'b1;
          frame_stb_d = 1'b1;
        end
      end
    end
  end

  // input pipeline resets to the idle (all-off) bus
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      seg_q          <= 7'h7F;
      seg_prev_q     <= 7'h7F;
      an_q           <= 4'hF;
      an_prev_q      <= 4'hF;
      stab_q         <= '0;
      run_on_q       <= 1'b0;
      run_q          <= '0;
      ptr_q          <= 2'd3;
      seen_q         <= 4'd0;
      shadow_q       <= 16'd0;
      shadow_blank_q <= 4'd0;
      digits_q       <= 16'd0;
      blank_q        <= 4'd0;
      valid_q        <= 1'b0;
      frame_stb_q    <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      seg_q          <= seg_d;
      seg_prev_q     <= seg_prev_d;
      an_q           <= an_d;
      an_prev_q      <= an_prev_d;
      stab_q         <= stab_d;
      run_on_q       <= run_on_d;
      run_q          <= run_d;
      ptr_q          <= ptr_d;
      seen_q         <= seen_d;
      shadow_q       <= shadow_d;
      shadow_blank_q <= shadow_blank_d;
      digits_q       <= digits_d;
      blank_q        <= blank_d;
      valid_q        <= valid_d;
      frame_stb_q    <= frame_stb_d;
      err_q          <= err_d;
    end
  end

  assign digits    = digits_q;
  assign blank     = blank_q;
  assign valid     = valid_q;
  assign frame_stb = frame_stb_q;
  assign err       = err_q;

endmodule

// File: tb/tb_x7seg_capture.sv
// Bench for x7seg_capture: drives scan-bus traffic slot by slot and compares
// frame/error activity against a slot-record reference model.
module tb_x7seg_capture;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [6:0]  a_to_g = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        valid, frame_stb, err;

  x7seg_capture #(.SLOT_CYCLES(16), .STABLE_CYCLES(2), .CNT_W(20)) dut (
    .clk(clk), .clr(clr), .a_to_g(a_to_g), .an(an),
    .digits(digits), .blank(blank), .valid(valid),
    .frame_stb(frame_stb), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_frames = 0;
  int obs_errs   = 0;
  logic [15:0] stb_digits = 16'd0;

  always @(negedge clk) begin
    if (frame_stb) begin
      obs_frames++;
      stb_digits = digits;
    end
    if (err) obs_errs++;
  end

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // reference model: one call per slot record
  int          m_frames = 0;
  int          m_errs   = 0;
  int          m_ptr;
  logic [3:0]  m_seen;
  logic [3:0]  m_sh [4];
  logic [3:0]  m_shb;
  logic [15:0] m_digits;
  logic [3:0]  m_blank;
  logic        m_valid;
  bit          bus_blank;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ptr = 3; m_seen = 4'd0; m_shb = 4'd0;
    m_digits = 16'd0; m_blank = 4'd0; m_valid = 1'b0;
    for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
    bus_blank = 1'b0;
  endtask

  task automatic model_record(input int slot, input logic [3:0] nib, input bit bad, input bit is_blank);
    bit e = bad;
    if (m_seen != 4'd0 && slot != (m_ptr + 1) % 4) begin
      e = 1'b1;
      m_seen = 4'(1 << slot);
    end else begin
      m_seen = m_seen | 4'(1 << slot);
    end
    if (e) m_errs++;
    m_sh[slot]  = bad ? 4'd0 : nib;
    m_shb[slot] = is_blank;
    m_ptr = slot;
    if (slot == 3) begin
      if (m_seen == 4'hF) begin
        m_digits = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
        m_blank  = m_shb;
        m_valid  = 1'b1;
        m_frames++;
      end
      m_seen = 4'd0;
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a;
    a_to_g = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic glitch();
    drive(4'b0000, 7'($urandom), 1);
  endtask

  task automatic lit_slot(input int k, input logic [3:0] nib, input bit bad);
    logic [3:0] a;
    a = ~(4'b0001 << k);
    glitch();
    drive(a, bad ? 7'h7F : seg_tab[nib], 15);
    bus_blank = 1'b0;
    model_record(k, nib, bad, 1'b0);
  endtask

  task automatic blank_slot();
    if (!bus_blank) begin
      glitch();
      drive(4'hF, 7'h7F, 15);
    end else begin
      drive(4'hF, 7'h7F, 16);
    end
    bus_blank = 1'b1;
    model_record((m_ptr + 1) % 4, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic multi_slot(input logic [3:0] a);
    glitch();
    drive(a, 7'($urandom), 15);
    bus_blank = 1'b0;
    m_errs++;
    m_seen = 4'd0;
  endtask

  task automatic scan(input logic [15:0] val, input int nblank, input int skip, input logic [3:0] bad_mask);
    for (int k = 0; k < 4; k++) begin
      if (k == skip) continue;
      if (k >= 4 - nblank) blank_slot();
      else lit_slot(k, val[4*k +: 4], bad_mask[k]);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_frames"}, obs_frames, m_frames);
    check({tag, "_errs"},   obs_errs,   m_errs);
    check({tag, "_digits"}, digits,     m_digits);
    check({tag, "_blank"},  blank,      m_blank);
    check({tag, "_valid"},  valid,      m_valid);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int nb, choice, skip;
    logic [15:0] val;
    logic [3:0]  bad;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits", digits, 16'd0);
    check("rst_blank",  blank, 4'd0);
    check("rst_valid",  valid, 1'b0);
    check("rst_stb",    frame_stb, 1'b0);
    check("rst_err",    err, 1'b0);
    clr = 1'b0;

    scan(16'h1234, 0, -1, 4'b0000);
    check_state("scan1234");
    check("scan1234_stb_digits", stb_digits, 16'h1234);

    scan(16'h005A, 2, -1, 4'b0000);
    check_state("blank2");
    check("blank2_literal", {digits, blank}, {16'h005A, 4'b1100});

    scan(16'h9807, 0, -1, 4'b0010);
    check_state("badseg");
    check("badseg_nibble", digits[7:4], 4'd0);

    multi_slot(4'b0101);
    check_state("multi");
    lit_slot(2, 4'h6, 1'b0);
    lit_slot(3, 4'h7, 1'b0);
    check_state("multi_partial");
    scan(16'h7654, 0, -1, 4'b0000);
    check_state("multi_recover");

    lit_slot(0, 4'h1, 1'b0);
    lit_slot(2, 4'h2, 1'b0);
    lit_slot(3, 4'h3, 1'b0);
    check_state("ooo");
    scan(16'hC0DE, 0, -1, 4'b0000);
    check_state("ooo_recover");

    for (int it = 0; it < 24; it++) begin
      val    = 16'($urandom);
      nb     = $urandom_range(0, 3);
      choice = $urandom_range(0, 5);
      bad    = 4'd0;
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 7) == 0) bad[k] = 1'b1;
      skip = (choice == 1 && nb <= 2) ? 1 : -1;
      if (choice == 0) multi_slot(4'b0011);
      scan(val, nb, skip, bad);
      check_state($sformatf("rand%0d", it));
    end

    scan(16'hABCD, 0, -1, 4'b0000);
    lit_slot(0, 4'h1, 1'b0);
    lit_slot(1, 4'h2, 1'b0);
    glitch();
    drive(4'b1011, seg_tab[3], 8);
    #2 clr = 1'b1;
    #1;
    check("clr_digits", digits, 16'd0);
    check("clr_blank",  blank, 4'd0);
    check("clr_valid",  valid, 1'b0);
    check("clr_stb",    frame_stb, 1'b0);
    check("clr_err",    err, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b0;
    scan(16'h4321, 0, -1, 4'b0000);
    check_state("after_clr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
